fold2_sample_feeder: RTL and testbench
======================================

Name: fold2_sample_feeder

Overview:
- Upstream stage of the 2-folded IIR filter core.
- Accepts input samples from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Generates the fold-phase `switch` signal and presents each sample on `Xn`, held stable for exactly the two clock cycles of one fold slot.
- Latches coefficient updates into shadow registers and drives `a`/`b` to the filter, changing them only at slot boundaries so a sample is never computed with mixed coefficients.

Parameters:
- N, 16, sample and coefficient width (two's complement).
- DEPTH, 4, FIFO depth in samples; power of two, at least 2.
- UCW, 8, width of the underrun counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  N  sample from the producer.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a sample; high when level < DEPTH.
- coef_a_in  input  N  new value for coefficient a.
- coef_b_in  input  N  new value for coefficient b.
- coef_load  input  1  capture coef_a_in/coef_b_in into the pending shadow registers.
- Xn  output  N  sample to the filter.
- a  output  N  active coefficient a.
- b  output  N  active coefficient b.
- switch  output  1  fold phase; 1 = slot cycle A, 0 = slot cycle B.
- sample_valid  output  1  high during cycle A when Xn holds a real sample rather than zero stuffing.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- underrun_cnt  output  UCW  saturating count of zero-stuffed slots.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - switch=1, Xn=0, a=0, b=0, sample_valid=0, level=0, underrun_cnt=0.
  - FIFO pointers = 0; pending coefficients = 0; pending-flag = 0.
  - in_ready=1 during and immediately after reset.
- Phase:
  - switch toggles on every rising edge after reset release.
  - The first edge after release takes switch 1->0.
  - A slot is one A cycle (switch=1) followed by one B cycle (switch=0).
- Push:
  - A push occurs on an edge where in_valid and in_ready are both 1; in_data is written at the write pointer.
  - in_valid while full is ignored; the data is dropped and the producer must hold it.
- Slot boundary = the edge where switch goes 0->1. At that edge:
  - If level > 0: pop the head into Xn and set sample_valid=1.
  - If level = 0: Xn<=0, sample_valid=0, underrun_cnt increments, saturating at all-ones.
  - If the pending-flag is set: a<=pending a, b<=pending b, pending-flag cleared.
- Mid-slot edge (1->0):
  - Xn, a and b are held.
  - sample_valid<=0, so it is high only in cycle A.
- Timing:
  - Xn changes only at slot boundaries.
  - Minimum latency from push to Xn is the next slot boundary after the push edge. No bypass: a push on the boundary edge itself is not visible until the following boundary.
- Simultaneous push and pop: both take effect and level is unchanged.
  - Push while empty at a boundary: the slot underruns and the pushed sample is stored.
  - Push while full never happens, because in_ready=0; there is no pop-frees-slot bypass in the same cycle.
- Pointers: wrap modulo DEPTH. level is the write count minus the read count, range 0..DEPTH.
- Coefficients:
  - coef_load on any edge overwrites the pending values and sets the pending-flag; the last load before a boundary wins.
  - coef_load on the boundary edge itself is applied at the next boundary, not the current one.
- Reset mid-operation: all state is cleared immediately; buffered samples are discarded; phase restarts with switch=1.
- Arithmetic: no arithmetic on data; values pass through bit-exact. Negative samples are preserved as two's complement.

Test Plan:
- Reset behaviour: hold rst low 3 cycles, then release -> switch=1, Xn=0, a=b=0, in_ready=1, level=0 during reset; switch toggles 1->0 on the first edge after release.
- Streaming: push -3, 5, 2, -2, 4, 1 (0xFFFD, 0x0005, 0x0002, 0xFFFE, 0x0004, 0x0001) one per slot, ahead of consumption -> Xn shows each value for exactly 2 cycles in order; sample_valid=1 in each A cycle; Xn never changes on the 1->0 edge.
- Underrun: stop pushing after 2 samples -> following slots give Xn=0 and sample_valid=0; underrun_cnt counts 1, 2, 3 per slot; force 300 underruns with UCW=8 -> underrun_cnt stays at 255.
- Backpressure: push 5 samples back-to-back with no pops pending (DEPTH=4) -> in_ready=0 once level=4; the 5th sample is not written until a boundary pop drops level to 3; the output order stays intact.
- Coefficient timing: a=2, b=3 active; pulse coef_load with 3 and 5 during cycle A -> a and b stay 2/3 through cycle B and become 3/5 exactly at the next 0->1 edge; two loads in one slot -> only the second is applied.
- Reset mid-stream: assert rst with level=3 during cycle B -> level=0, Xn=0, switch=1 immediately (asynchronous); after release the next pushed sample is the first one seen on Xn.

Source files
------------

// File: rtl/fold2_sample_feeder.sv
// Sample feeder for the 2-folded IIR core: FIFO-buffered input, fold phase generation,
// one sample per two-cycle slot, coefficient shadow registers swapped only at slot boundaries.
module fold2_sample_feeder #(
   parameter int N     = 16,
   parameter int DEPTH = 4,
   parameter int UCW   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           coef_a_in,
   input  logic [N-1:0]           coef_b_in,
   input  logic                   coef_load,
   output logic [N-1:0]           Xn,
   output logic [N-1:0]           a,
   output logic [N-1:0]           b,
   output logic                   switch,
   output logic                   sample_valid,
   output logic [$clog2(DEPTH):0] level,
   output logic [UCW-1:0]         underrun_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [N-1:0]   mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic           switch_q, switch_d;
   logic           sample_valid_q, sample_valid_d;
   logic [N-1:0]   xn_q, xn_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [N-1:0]   pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic           pend_vld_q, pend_vld_d;
   logic [UCW-1:0] ucnt_q, ucnt_d;
   logic [AW:0]    level_w;
   logic           boundary, push, pop;

   // Pointers carry one extra bit so full (level == DEPTH) is distinguishable from empty.
   assign level_w  = wr_ptr_q - rd_ptr_q;
   assign in_ready = (level_w != FULL);
   assign boundary = ~switch_q;
   assign push     = in_valid & in_ready;
   assign pop      = boundary & (level_w != '0);

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      switch_d       = ~switch_q;
      sample_valid_d = 1'b0;
      xn_d           = xn_q;
      a_d            = a_q;
      b_d            = b_q;
      pend_a_d       = pend_a_q;
      pend_b_d       = pend_b_q;
      pend_vld_d     = pend_vld_q;
      ucnt_d         = ucnt_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (boundary) begin
         if (pop) begin
            xn_d           = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d       = rd_ptr_q + 1'b1;
            sample_valid_d = 1'b1;
         end else begin
            xn_d = '0;
            if (ucnt_q != '1) begin
               ucnt_d = ucnt_q + 1'b1;
            end
         end
         if (pend_vld_q) begin
            a_d        = pend_a_q;
            b_d        = pend_b_q;
            pend_vld_d = 1'b0;
         end
      end

      // A load on the boundary edge itself re-arms the flag for the next boundary.
      if (coef_load) begin
         pend_a_d   = coef_a_in;
         pend_b_d   = coef_b_in;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         switch_q       <= 1'b1;
         sample_valid_q <= 1'b0;
         xn_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         pend_a_q       <= '0;
         pend_b_q       <= '0;
         pend_vld_q     <= 1'b0;
         ucnt_q         <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         switch_q       <= switch_d;
         sample_valid_q <= sample_valid_d;
         xn_q           <= xn_d;
         a_q            <= a_d;
         b_q            <= b_d;
         pend_a_q       <= pend_a_d;
         pend_b_q       <= pend_b_d;
         pend_vld_q     <= pend_vld_d;
         ucnt_q         <= ucnt_d;
      end
   end

   assign Xn           = xn_q;
   assign a            = a_q;
   assign b            = b_q;
   assign switch       = switch_q;
   assign sample_valid = sample_valid_q;
   assign level        = level_w;
   assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_fold2_sample_feeder.sv
// Bench for fold2_sample_feeder: directed vector table, hand sequences for reset/backpressure/saturation,
// and a randomized run against a queue-based slot model.
module tb_fold2_sample_feeder;
   localparam int N     = 16;
   localparam int DEPTH = 4;
   localparam int UCW   = 8;
   localparam int UMAX  = (1 << UCW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  coef_a_in, coef_b_in;
   logic          coef_load;
   logic [N-1:0]  Xn, a, b;
   logic          switch;
   logic          sample_valid;
   logic [2:0]    level;
   logic [UCW-1:0] underrun_cnt;

   fold2_sample_feeder #(.N(N), .DEPTH(DEPTH), .UCW(UCW)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .coef_a_in(coef_a_in), .coef_b_in(coef_b_in), .coef_load(coef_load),
      .Xn(Xn), .a(a), .b(b), .switch(switch), .sample_valid(sample_valid),
      .level(level), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Slot-level reference: a queue of buffered samples, a phase bit, and the visible outputs.
   logic [N-1:0] q_m[$];
   bit           m_sw, m_sv, m_pf;
   logic [N-1:0] m_xn, m_a, m_b, m_pa, m_pb;
   int           m_ucnt;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_m.delete();
      m_sw = 1'b1; m_sv = 1'b0; m_pf = 1'b0;
      m_xn = '0; m_a = '0; m_b = '0; m_pa = '0; m_pb = '0;
      m_ucnt = 0;
   endtask

   task automatic model_edge(bit vld, logic [N-1:0] dat, bit ld, logic [N-1:0] ca, logic [N-1:0] cb);
      bit accept;
      accept = vld && (q_m.size() < DEPTH);
      if (!m_sw) begin
         if (q_m.size() > 0) begin
            m_xn = q_m.pop_front();
            m_sv = 1'b1;
         end else begin
            m_xn = '0;
            m_sv = 1'b0;
            if (m_ucnt < UMAX) m_ucnt++;
         end
         if (m_pf) begin
            m_a = m_pa; m_b = m_pb; m_pf = 1'b0;
         end
      end else begin
         m_sv = 1'b0;
      end
      if (accept) q_m.push_back(dat);
      if (ld) begin
         m_pa = ca; m_pb = cb; m_pf = 1'b1;
      end
      m_sw = !m_sw;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_edge(in_valid, in_data, coef_load, coef_a_in, coef_b_in);
      #1;
   endtask

   task automatic check_model(string tag);
      chk({tag, ".switch"}, 32'(switch), 32'(m_sw));
      chk({tag, ".Xn"}, 32'(Xn), 32'(m_xn));
      chk({tag, ".sample_valid"}, 32'(sample_valid), 32'(m_sv));
      chk({tag, ".a"}, 32'(a), 32'(m_a));
      chk({tag, ".b"}, 32'(b), 32'(m_b));
      chk({tag, ".level"}, 32'(level), 32'(q_m.size()));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(q_m.size() < DEPTH));
      chk({tag, ".underrun_cnt"}, 32'(underrun_cnt), 32'(m_ucnt));
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = '0; coef_load = 1'b0; coef_a_in = '0; coef_b_in = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      tick();
      tick();
      rst = 1'b1;
   endtask

   typedef struct {
      logic       vld;
      logic [N-1:0] dat;
      logic       ld;
      logic [N-1:0] ca, cb;
      logic       sw;
      logic [N-1:0] xn;
      logic       sv;
      logic [N-1:0] ea, eb;
      logic [2:0] lv;
      logic [UCW-1:0] uc;
   } vec_t;

   function automatic vec_t mk(int vld, int dat, int ld, int ca, int cb,
                               int sw, int xn, int sv, int ea, int eb, int lv, int uc);
      vec_t v;
      v.vld = vld[0]; v.dat = dat[N-1:0]; v.ld = ld[0]; v.ca = ca[N-1:0]; v.cb = cb[N-1:0];
      v.sw = sw[0]; v.xn = xn[N-1:0]; v.sv = sv[0]; v.ea = ea[N-1:0]; v.eb = eb[N-1:0];
      v.lv = lv[2:0]; v.uc = uc[UCW-1:0];
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      logic [N-1:0] bp[8];
      logic [N-1:0] got[$];
      int  idx, p;
      bit  found, saw_full, rdy_before;

      // Inputs applied before each edge and the outputs expected right after it, from reset release.
      tbl[0]  = mk(1, 'hFFFD, 1,  2,  3,  0, 0,      0, 0,  0,  1, 0);
      tbl[1]  = mk(1, 'h0005, 0,  0,  0,  1, 'hFFFD, 1, 2,  3,  1, 0);
      tbl[2]  = mk(0, 0,      1,  3,  5,  0, 'hFFFD, 0, 2,  3,  1, 0);
      tbl[3]  = mk(0, 0,      0,  0,  0,  1, 'h0005, 1, 3,  5,  0, 0);
      tbl[4]  = mk(0, 0,      1,  7,  9,  0, 'h0005, 0, 3,  5,  0, 0);
      tbl[5]  = mk(0, 0,      1, 11, 13,  1, 0,      0, 7,  9,  0, 1);
      tbl[6]  = mk(1, 'h0002, 1, 15, 17,  0, 0,      0, 7,  9,  1, 1);
      tbl[7]  = mk(0, 0,      0,  0,  0,  1, 'h0002, 1, 15, 17, 0, 1);
      tbl[8]  = mk(1, 'hFFFE, 0,  0,  0,  0, 'h0002, 0, 15, 17, 1, 1);
      tbl[9]  = mk(1, 'h0004, 0,  0,  0,  1, 'hFFFE, 1, 15, 17, 1, 1);
      tbl[10] = mk(0, 0,      0,  0,  0,  0, 'hFFFE, 0, 15, 17, 1, 1);
      tbl[11] = mk(0, 0,      0,  0,  0,  1, 'h0004, 1, 15, 17, 0, 1);
      tbl[12] = mk(0, 0,      0,  0,  0,  0, 'h0004, 0, 15, 17, 0, 1);
      tbl[13] = mk(1, 'h0001, 0,  0,  0,  1, 0,      0, 15, 17, 1, 2);
      tbl[14] = mk(0, 0,      0,  0,  0,  0, 0,      0, 15, 17, 1, 2);
      tbl[15] = mk(0, 0,      0,  0,  0,  1, 'h0001, 1, 15, 17, 0, 2);

      idle_inputs();
      rst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_model("reset");
      end
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         in_valid = tbl[i].vld; in_data = tbl[i].dat;
         coef_load = tbl[i].ld; coef_a_in = tbl[i].ca; coef_b_in = tbl[i].cb;
         tick();
         chk($sformatf("tbl%0d.switch", i), 32'(switch), 32'(tbl[i].sw));
         chk($sformatf("tbl%0d.Xn", i), 32'(Xn), 32'(tbl[i].xn));
         chk($sformatf("tbl%0d.sample_valid", i), 32'(sample_valid), 32'(tbl[i].sv));
         chk($sformatf("tbl%0d.a", i), 32'(a), 32'(tbl[i].ea));
         chk($sformatf("tbl%0d.b", i), 32'(b), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].lv));
         chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'd1);
         chk($sformatf("tbl%0d.underrun_cnt", i), 32'(underrun_cnt), 32'(tbl[i].uc));
      end
      idle_inputs();

      // Mid-stream asynchronous reset during cycle B with three samples buffered.
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         in_valid = 1'b1; in_data = 16'(16'hA000 + i);
         tick();
         check_model("midrst_fill");
         if (q_m.size() == 3 && !m_sw) found = 1'b1;
      end
      chk("midrst_reach_level3", 32'(found), 32'd1);
      idle_inputs();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("midrst.level", 32'(level), 32'd0);
      chk("midrst.Xn", 32'(Xn), 32'd0);
      chk("midrst.switch", 32'(switch), 32'd1);
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b1;
      in_valid = 1'b1; in_data = 16'h1234;
      tick();
      check_model("midrst_push");
      idle_inputs();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         check_model("midrst_wait");
         if (sample_valid) begin
            found = 1'b1;
            chk("midrst.first_Xn", 32'(Xn), 32'h1234);
         end
      end
      chk("midrst_first_seen", 32'(found), 32'd1);

      // Backpressure: producer holds each sample until accepted.
      do_reset();
      for (int i = 0; i < 8; i++) bp[i] = 16'($urandom);
      idx = 0; saw_full = 1'b0;
      for (int i = 0; i < 60 && idx < 8; i++) begin
         rdy_before = in_ready;
         in_valid = 1'b1; in_data = bp[idx];
         tick();
         check_model("bp");
         if (rdy_before) idx++;
         if (!in_ready) saw_full = 1'b1;
         if (sample_valid) got.push_back(Xn);
      end
      chk("bp_all_accepted", 32'(idx), 32'd8);
      chk("bp_full_seen", 32'(saw_full), 32'd1);
      idle_inputs();
      for (int i = 0; i < 20; i++) begin
         tick();
         check_model("bp_drain");
         if (sample_valid) got.push_back(Xn);
      end
      chk("bp_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'(bp[i]));

      // Underrun counter saturation: 310 empty slots.
      do_reset();
      for (int i = 0; i < 620; i++) begin
         tick();
         check_model("sat");
      end
      chk("sat.underrun_cnt", 32'(underrun_cnt), 32'(UMAX));

      // Randomized traffic, first heavy then light producer.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         p = (i < 1000) ? 75 : 30;
         in_valid  = ($urandom_range(99) < p);
         in_data   = 16'($urandom);
         coef_load = ($urandom_range(99) < 15);
         coef_a_in = 16'($urandom);
         coef_b_in = 16'($urandom);
         tick();
         check_model("rand");
      end
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
